// File: rtl/gon_tx.sv
// GON X-bus source: buffers tagged words through a small FIFO and drives them onto the bus,
// and serially programs the multicast controllers' ID scan chain before a layer starts.
module gon_tx #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned ROW_TAG_WIDTH = 4,
  parameter int unsigned COL_TAG_WIDTH = 4,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned SCAN_LEN      = 56
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic [ROW_TAG_WIDTH-1:0] in_row_tag,
  input  logic [COL_TAG_WIDTH-1:0] in_col_tag,
  input  logic                     cfg_start,
  input  logic [SCAN_LEN-1:0]      cfg_ids,
  output logic                     cfg_busy,
  output logic                     cfg_done,
  output logic                     scan_en_id,
  output logic                     scan_out_id,
  output logic [DATA_WIDTH-1:0]    gon_data,
  output logic [ROW_TAG_WIDTH-1:0] gon_row_tag,
  output logic [COL_TAG_WIDTH-1:0] gon_col_tag,
  output logic                     gon_enable,
  input  logic                     gon_ready,
  output logic                     idle
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned SCNT_W  = $clog2(SCAN_LEN + 1);
  localparam int unsigned ENTRY_W = DATA_WIDTH + ROW_TAG_WIDTH + COL_TAG_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, SCAN} state_e;

  state_e                   state_q, state_d;
  logic [ENTRY_W-1:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     in_ready_q, in_ready_d;
  logic                     pend_q, pend_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     scan_en_q, scan_en_d;
  logic                     scan_out_q, scan_out_d;
  logic [SCAN_LEN-1:0]      shreg_q, shreg_d;
  logic [SCNT_W-1:0]        scnt_q, scnt_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic [ROW_TAG_WIDTH-1:0] row_q, row_d;
  logic [COL_TAG_WIDTH-1:0] col_q, col_d;
  logic                     en_q, en_d;
  logic                     idle_q, idle_d;
  logic                     push, pop, can_load;
  logic [ENTRY_W-1:0]       head;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pend_d     = pend_q;
    done_d     = 1'b0;
    scan_en_d  = scan_en_q;
    scan_out_d = scan_out_q;
    shreg_d    = shreg_q;
    scnt_d     = scnt_q;
    data_d     = data_q;
    row_d      = row_q;
    col_d      = col_q;
    en_d       = en_q;
    pop        = 1'b0;
    push       = in_valid && in_ready_q;
    head       = mem_q[rd_ptr_q];
    // A pending scan request freezes loading so the bus drains before the chain is shifted.
    can_load   = (count_q != CNT_W'(0)) && (state_q != SCAN) && !pend_q;

    if (!en_q || gon_ready) begin
      if (can_load) begin
        pop    = 1'b1;
        en_d   = 1'b1;
        data_d = head[ENTRY_W-1 -: DATA_WIDTH];
        row_d  = head[COL_TAG_WIDTH +: ROW_TAG_WIDTH];
        col_d  = head[COL_TAG_WIDTH-1:0];
      end else begin
        en_d = 1'b0;
      end
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    if (cfg_start && !busy_q) pend_d = 1'b1;

    case (state_q)
      IDLE, RUN: begin
        if (pend_q && !en_q) begin
          state_d    = SCAN;
          pend_d     = 1'b0;
          shreg_d    = cfg_ids;
          scnt_d     = SCNT_W'(SCAN_LEN);
          scan_en_d  = 1'b1;
          scan_out_d = cfg_ids[SCAN_LEN-1];
        end else begin
          state_d = ((count_d != CNT_W'(0)) || en_d) ? RUN : IDLE;
        end
      end
      SCAN: begin
        // scnt counts bits still on the wire, including the one currently driven.
        shreg_d = shreg_q << 1;
        if (scnt_q == SCNT_W'(1)) begin
          scan_en_d  = 1'b0;
          scan_out_d = 1'b0;
          done_d     = 1'b1;
          state_d    = (count_d != CNT_W'(0)) ? RUN : IDLE;
        end else begin
          scnt_d     = scnt_q - SCNT_W'(1);
          scan_out_d = shreg_q[SCAN_LEN-2];
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d     = pend_d || (state_d == SCAN);
    in_ready_d = (count_d != CNT_W'(FIFO_DEPTH));
    idle_d     = (count_d == CNT_W'(0)) && !en_d && (state_d != SCAN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
      pend_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      scan_en_q  <= 1'b0;
      scan_out_q <= 1'b0;
      shreg_q    <= '0;
      scnt_q     <= '0;
      data_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      en_q       <= 1'b0;
      idle_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      pend_q     <= pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      scan_en_q  <= scan_en_d;
      scan_out_q <= scan_out_d;
      shreg_q    <= shreg_d;
      scnt_q     <= scnt_d;
      data_q     <= data_d;
      row_q      <= row_d;
      col_q      <= col_d;
      en_q       <= en_d;
      idle_q     <= idle_d;
    end
  end

  // FIFO storage carries no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_data, in_row_tag, in_col_tag};
  end

  assign in_ready    = in_ready_q;
  assign cfg_busy    = busy_q;
  assign cfg_done    = done_q;
  assign scan_en_id  = scan_en_q;
  assign scan_out_id = scan_out_q;
  assign gon_data    = data_q;
  assign gon_row_tag = row_q;
  assign gon_col_tag = col_q;
  assign gon_enable  = en_q;
  assign idle        = idle_q;

endmodule

// File: tb/tb_gon_tx.sv
// Self-checking bench for gon_tx: vector table for single beats, scoreboard for bus ordering,
// and hand-written sequences for stall, full, scan and reset-during-scan behaviour.
module tb_gon_tx;

  localparam int unsigned DW = 64;
  localparam int unsigned RW = 4;
  localparam int unsigned CW = 4;
  localparam int unsigned SL = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic [RW-1:0] in_row_tag;
  logic [CW-1:0] in_col_tag;
  logic          cfg_start, cfg_busy, cfg_done;
  logic [SL-1:0] cfg_ids;
  logic          scan_en_id, scan_out_id;
  logic [DW-1:0] gon_data;
  logic [RW-1:0] gon_row_tag;
  logic [CW-1:0] gon_col_tag;
  logic          gon_enable, gon_ready, idle;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [RW-1:0] r;
    logic [CW-1:0] c;
  } word_t;

  typedef struct {
    word_t         in_w;
    logic [DW-1:0] exp_d;
    logic [RW-1:0] exp_r;
    logic [CW-1:0] exp_c;
  } vec_t;

  word_t sb_q[$];

  gon_tx #(
    .DATA_WIDTH(DW), .ROW_TAG_WIDTH(RW), .COL_TAG_WIDTH(CW), .FIFO_DEPTH(4), .SCAN_LEN(SL)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_row_tag(in_row_tag), .in_col_tag(in_col_tag),
    .cfg_start(cfg_start), .cfg_ids(cfg_ids), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
    .scan_en_id(scan_en_id), .scan_out_id(scan_out_id),
    .gon_data(gon_data), .gon_row_tag(gon_row_tag), .gon_col_tag(gon_col_tag),
    .gon_enable(gon_enable), .gon_ready(gon_ready), .idle(idle)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required run to finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Pop/compare on completed beats, push on accepted words; sampled mid-cycle.
  task automatic sb_step();
    word_t e;
    if (gon_enable && gon_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_beat", 64'(gon_data), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        chk("sb_data", gon_data, e.d);
        chk("sb_row", 64'(gon_row_tag), 64'(e.r));
        chk("sb_col", 64'(gon_col_tag), 64'(e.c));
      end
    end
    if (in_valid && in_ready) sb_q.push_back('{d: in_data, r: in_row_tag, c: in_col_tag});
  endtask

  task automatic tick();
    @(negedge clk);
    sb_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input word_t w);
    in_valid   = 1'b1;
    in_data    = w.d;
    in_row_tag = w.r;
    in_col_tag = w.c;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) tick();
    chk("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_idle"}, 64'(idle), 64'd1);
    chk({tag, "_gon_enable"}, 64'(gon_enable), 64'd0);
    chk({tag, "_gon_data"}, gon_data, 64'd0);
    chk({tag, "_gon_tags"}, 64'({gon_row_tag, gon_col_tag}), 64'd0);
    chk({tag, "_cfg_busy"}, 64'(cfg_busy), 64'd0);
    chk({tag, "_cfg_done"}, 64'(cfg_done), 64'd0);
    chk({tag, "_scan_en"}, 64'(scan_en_id), 64'd0);
    chk({tag, "_scan_out"}, 64'(scan_out_id), 64'd0);
  endtask

  initial begin
    vec_t          vecs[4];
    word_t         w[6];
    logic [SL-1:0] ids;
    int            accepted;
    logic          done_seen;

    vecs[0] = '{in_w: '{d: 64'hA5, r: 4'd2, c: 4'd5}, exp_d: 64'hA5, exp_r: 4'd2, exp_c: 4'd5};
    vecs[1] = '{in_w: '{d: 64'hFFFF_FFFF_FFFF_FFFF, r: 4'hF, c: 4'hF},
                exp_d: 64'hFFFF_FFFF_FFFF_FFFF, exp_r: 4'hF, exp_c: 4'hF};
    vecs[2] = '{in_w: '{d: 64'h0, r: 4'h0, c: 4'h0}, exp_d: 64'h0, exp_r: 4'h0, exp_c: 4'h0};
    vecs[3] = '{in_w: '{d: 64'h8000_0000_1234_5678, r: 4'h9, c: 4'h6},
                exp_d: 64'h8000_0000_1234_5678, exp_r: 4'h9, exp_c: 4'h6};
    for (int i = 0; i < 6; i++) begin
      w[i].d = 64'hDEAD_BEEF_0000_0000 + 64'(i * 17 + 1);
      w[i].r = 4'(i + 1);
      w[i].c = 4'(15 - i);
    end

    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_row_tag = '0; in_col_tag = '0;
    cfg_start = 1'b0; cfg_ids = '0; gon_ready = 1'b0;
    #1;
    check_reset_outputs("rst");
    @(posedge clk); #1;
    reset = 1'b0;
    tick();

    // Single words from the vector table: one cycle latency, one-cycle beat, back to idle.
    for (int v = 0; v < 4; v++) begin
      gon_ready = 1'b1;
      drive_word(vecs[v].in_w);
      tick();
      in_valid = 1'b0;
      chk("vec_not_yet", 64'(gon_enable), 64'd0);
      tick();
      chk("vec_enable", 64'(gon_enable), 64'd1);
      chk("vec_data", gon_data, vecs[v].exp_d);
      chk("vec_row", 64'(gon_row_tag), 64'(vecs[v].exp_r));
      chk("vec_col", 64'(gon_col_tag), 64'(vecs[v].exp_c));
      chk("vec_busy_idle", 64'(idle), 64'd0);
      tick();
      chk("vec_enable_drop", 64'(gon_enable), 64'd0);
      chk("vec_idle", 64'(idle), 64'd1);
    end
    drain(2);

    // Stall: first word held while ready is low, then three consecutive beats.
    gon_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_word(w[i]);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("stall_enable", 64'(gon_enable), 64'd1);
      chk("stall_data", gon_data, w[0].d);
      chk("stall_in_ready", 64'(in_ready), 64'd1);
      tick();
    end
    gon_ready = 1'b1;
    tick();
    chk("b2b_beat1", 64'(gon_enable), 64'd1);
    chk("b2b_data1", gon_data, w[1].d);
    tick();
    chk("b2b_beat2", 64'(gon_enable), 64'd1);
    chk("b2b_data2", gon_data, w[2].d);
    tick();
    chk("b2b_end", 64'(gon_enable), 64'd0);
    drain(4);

    // Full: five words fit (output register plus four FIFO entries).
    gon_ready = 1'b0;
    accepted  = 0;
    for (int i = 0; i < 6; i++) begin
      drive_word(w[i]);
      if (in_ready) accepted++;
      tick();
    end
    in_valid = 1'b0;
    chk("full_accepted", 64'(accepted), 64'd5);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    gon_ready = 1'b1;
    tick();
    gon_ready = 1'b0;
    chk("full_reassert", 64'(in_ready), 64'd1);
    tick();
    gon_ready = 1'b1;
    drain(20);
    tick();

    // ID scan on an idle bus.
    ids = 8'b1011_0010;
    cfg_ids = ids;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("scan_busy_pend", 64'(cfg_busy), 64'd1);
    chk("scan_not_started", 64'(scan_en_id), 64'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("scan_en", 64'(scan_en_id), 64'd1);
      chk("scan_bit", 64'(scan_out_id), 64'(ids[7-i]));
      chk("scan_no_bus", 64'(gon_enable), 64'd0);
      chk("scan_no_done", 64'(cfg_done), 64'd0);
      tick();
    end
    chk("scan_en_off", 64'(scan_en_id), 64'd0);
    chk("scan_out_off", 64'(scan_out_id), 64'd0);
    chk("scan_done", 64'(cfg_done), 64'd1);
    chk("scan_busy_off", 64'(cfg_busy), 64'd0);
    tick();
    chk("scan_done_pulse", 64'(cfg_done), 64'd0);
    chk("scan_idle", 64'(idle), 64'd1);

    // Config request during a stalled beat with two words queued.
    gon_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_word(w[i + 3]);
      tick();
    end
    in_valid = 1'b0;
    chk("traf_stalled", 64'(gon_enable), 64'd1);
    cfg_ids = 8'h5A;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("traf_busy", 64'(cfg_busy), 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk("traf_hold_en", 64'(gon_enable), 64'd1);
      chk("traf_hold_data", gon_data, w[3].d);
      chk("traf_no_scan", 64'(scan_en_id), 64'd0);
      tick();
    end
    gon_ready = 1'b1;
    tick();
    chk("traf_beat_done", 64'(gon_enable), 64'd0);
    chk("traf_scan_wait", 64'(scan_en_id), 64'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("traf_scan_en", 64'(scan_en_id), 64'd1);
      chk("traf_scan_no_bus", 64'(gon_enable), 64'd0);
      tick();
    end
    chk("traf_done", 64'(cfg_done), 64'd1);
    chk("traf_done_no_bus", 64'(gon_enable), 64'd0);
    tick();
    chk("traf_resume", 64'(gon_enable), 64'd1);
    chk("traf_resume_data", gon_data, w[4].d);
    drain(10);
    tick();

    // Reset on scan bit 3 abandons the scan.
    cfg_ids = 8'hC3;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    tick();
    tick(); tick(); tick();
    chk("rscan_active", 64'(scan_en_id), 64'd1);
    reset = 1'b1;
    #1;
    check_reset_outputs("rscan");
    tick(); tick();
    reset = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (cfg_done || scan_en_id) done_seen = 1'b1;
    end
    chk("rscan_no_done", 64'(done_seen), 64'd0);
    chk("rscan_idle", 64'(idle), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
